// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_LOAD_STALL = 3'd1,
      ST_BR_FLUSH   = 3'd2,
      ST_MEM_WAIT   = 3'd3,
      ST_ERR        = 3'd4
   } state_t;

   localparam logic [1:0] MEM_R_NONE = 2'b11;
   localparam logic [1:0] MEM_W_NONE = 2'b11;
   localparam logic [4:0] REG_X0     = 5'd0;

   // Load in ID/EX writes a non-x0 register that the ID instruction reads.
   function automatic logic load_use_hit(
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs2,
      input logic [4:0] rd,
      input logic [1:0] mem_r,
      input logic       reg_w
   );
      return (mem_r != MEM_R_NONE) && reg_w && (rd != REG_X0) &&
             ((rd == rs1) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
module sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count up on inc, hold once all-ones is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes,
// data-memory wait freezes with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       idex_rd,
   input  logic [1:0]       idex_mem_r,
   input  logic             idex_reg_w,
   input  logic             exmem_brnc,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mem_stall,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              hazard;
   logic              mem_busy;
   logic              wait_last;

   assign hazard    = load_use_hit(id_rs1, id_rs2, id_uses_rs2,
                                   idex_rd, idex_mem_r, idex_reg_w);
   assign mem_busy  = dmem_req && !dmem_ready;
   // Current wait cycle is the MEM_TIMEOUT-th one without ready.
   assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Wait counter: zero outside MEM_WAIT, counts cycles spent waiting.
   always_ff @(posedge clk) begin
      if (rst || (state != ST_MEM_WAIT)) begin
         wait_cnt <= '0;
      end else if (!dmem_ready) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Next state and combinational pipeline controls.
   always_comb begin
      state_nxt   = state;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mem_stall   = 1'b0;
      timeout_err = 1'b0;
      if (rst) begin
         state_nxt   = ST_RUN;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_busy) begin
                  pc_en     = 1'b0;
                  ifid_en   = 1'b0;
                  mem_stall = 1'b1;
                  state_nxt = ST_MEM_WAIT;
               end else if (exmem_brnc) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  state_nxt   = ST_BR_FLUSH;
               end else if (hazard) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  state_nxt  = ST_LOAD_STALL;
               end
            end
            // Bubble already in flight; stale branch/hazard inputs ignored.
            ST_LOAD_STALL: state_nxt = ST_RUN;
            ST_BR_FLUSH:   state_nxt = ST_RUN;
            ST_MEM_WAIT: begin
               if (dmem_ready) begin
                  state_nxt = ST_RUN;
               end else begin
                  pc_en     = 1'b0;
                  ifid_en   = 1'b0;
                  mem_stall = 1'b1;
                  if (wait_last) begin
                     state_nxt = ST_ERR;
                  end
               end
            end
            ST_ERR: begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               mem_stall   = 1'b1;
               timeout_err = 1'b1;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   // Count cycles where the PC is held.
   sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!pc_en && !rst),
      .cnt (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, idex_rd;
   logic        id_uses_rs2, idex_reg_w, exmem_brnc, dmem_req, dmem_ready;
   logic [1:0]  idex_mem_r;

   logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
   logic        mem_stall, timeout_err;
   logic [15:0] stall_cnt;

   logic        d4_pc_en, d4_ifid_en, d4_ifid_flush, d4_idex_flush;
   logic        d4_exmem_flush, d4_mem_stall, d4_timeout_err;
   logic [3:0]  d4_stall_cnt;

   logic [6:0]  outs;
   int          n_cmp = 0;
   int          n_err = 0;

   // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, mem_stall, timeout_err}
   localparam logic [6:0] O_RUN = 7'b1100000;
   localparam logic [6:0] O_LU  = 7'b0001000;
   localparam logic [6:0] O_BR  = 7'b1111100;
   localparam logic [6:0] O_MEM = 7'b0000010;
   localparam logic [6:0] O_ERR = 7'b0000011;
   localparam logic [6:0] O_RST = 7'b0011100;

   assign outs = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
                  mem_stall, timeout_err};

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd), .idex_mem_r(idex_mem_r),
      .idex_reg_w(idex_reg_w), .exmem_brnc(exmem_brnc), .dmem_req(dmem_req),
      .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .mem_stall(mem_stall),
      .timeout_err(timeout_err), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd), .idex_mem_r(idex_mem_r),
      .idex_reg_w(idex_reg_w), .exmem_brnc(exmem_brnc), .dmem_req(dmem_req),
      .dmem_ready(dmem_ready), .pc_en(d4_pc_en), .ifid_en(d4_ifid_en),
      .ifid_flush(d4_ifid_flush), .idex_flush(d4_idex_flush),
      .exmem_flush(d4_exmem_flush), .mem_stall(d4_mem_stall),
      .timeout_err(d4_timeout_err), .stall_cnt(d4_stall_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_ex(input logic [4:0] rd, input logic [1:0] mr,
                         input logic rw);
      idex_rd    = rd;
      idex_mem_r = mr;
      idex_reg_w = rw;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
      set_ex(5'd0, 2'b11, 1'b0);
      exmem_brnc = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

      // Reset state
      cyc(); cyc(); mid();
      check_val("rst_outs", 32'(outs), 32'(O_RST));
      check_val("rst_cnt", 32'(stall_cnt), 32'd0);
      cyc(); rst = 1'b0; mid();
      check_val("first_run", 32'(outs), 32'(O_RUN));

      // Load-use on rs1, held so RUN re-detects after the bubble
      cyc(); set_ex(5'd5, 2'b00, 1'b1); id_rs1 = 5'd5; mid();
      check_val("lu_rs1", 32'(outs), 32'(O_LU));
      cyc(); mid();
      check_val("lu_stall_state", 32'(outs), 32'(O_RUN));
      check_val("lu_cnt1", 32'(stall_cnt), 32'd1);
      cyc(); mid();
      check_val("lu_again", 32'(outs), 32'(O_LU));
      cyc(); set_ex(5'd0, 2'b11, 1'b0); mid();
      check_val("lu_stall_state2", 32'(outs), 32'(O_RUN));
      cyc(); mid();
      check_val("lu_cnt2", 32'(stall_cnt), 32'd2);

      // Non-hazards
      cyc(); set_ex(5'd0, 2'b00, 1'b1); id_rs1 = 5'd0; mid();
      check_val("rd_x0", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd7, 2'b00, 1'b1); id_rs1 = 5'd3; id_rs2 = 5'd7;
      id_uses_rs2 = 1'b0; mid();
      check_val("rs2_unused", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd7, 2'b11, 1'b1); id_uses_rs2 = 1'b1; mid();
      check_val("not_load", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd7, 2'b10, 1'b0); mid();
      check_val("no_reg_w", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd7, 2'b01, 1'b1); mid();
      check_val("lu_rs2", 32'(outs), 32'(O_LU));
      cyc(); set_ex(5'd0, 2'b11, 1'b0); id_uses_rs2 = 1'b0; mid();
      check_val("lu_rs2_bubble", 32'(outs), 32'(O_RUN));
      cyc(); mid();
      check_val("lu_cnt3", 32'(stall_cnt), 32'd3);

      // Branch held two cycles, then branch racing a load-use
      cyc(); exmem_brnc = 1'b1; mid();
      check_val("br_first", 32'(outs), 32'(O_BR));
      cyc(); mid();
      check_val("br_second", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd5, 2'b00, 1'b1); id_rs1 = 5'd5; mid();
      check_val("br_over_lu", 32'(outs), 32'(O_BR));
      cyc(); exmem_brnc = 1'b0; mid();
      check_val("br_lu_supp", 32'(outs), 32'(O_RUN));
      cyc(); set_ex(5'd0, 2'b11, 1'b0); mid();
      check_val("br_cnt", 32'(stall_cnt), 32'd3);

      // Memory wait released after 3 stall cycles
      cyc(); dmem_req = 1'b1; mid();
      check_val("mw_enter", 32'(outs), 32'(O_MEM));
      for (int i = 0; i < 2; i++) begin
         cyc(); mid();
         check_val("mw_hold", 32'(outs), 32'(O_MEM));
      end
      cyc(); dmem_ready = 1'b1; mid();
      check_val("mw_release", 32'(outs), 32'(O_RUN));
      cyc(); dmem_req = 1'b0; dmem_ready = 1'b0; mid();
      check_val("mw_back_run", 32'(outs), 32'(O_RUN));
      check_val("mw_cnt", 32'(stall_cnt), 32'd6);
      cyc(); dmem_req = 1'b1; dmem_ready = 1'b1; mid();
      check_val("req_ready_same", 32'(outs), 32'(O_RUN));

      // Memory wait beats branch; branch taken after release
      cyc(); dmem_ready = 1'b0; exmem_brnc = 1'b1; mid();
      check_val("mw_over_br", 32'(outs), 32'(O_MEM));
      cyc(); dmem_ready = 1'b1; mid();
      check_val("mw_br_release", 32'(outs), 32'(O_RUN));
      cyc(); dmem_req = 1'b0; dmem_ready = 1'b0; mid();
      check_val("br_after_mw", 32'(outs), 32'(O_BR));
      cyc(); exmem_brnc = 1'b0; mid();
      check_val("br_after_mw_flush", 32'(outs), 32'(O_RUN));
      check_val("mw_br_cnt", 32'(stall_cnt), 32'd7);

      // Timeout: RUN stall cycle + 15 wait cycles, then ERR
      cyc(); dmem_req = 1'b1; mid();
      check_val("to_enter", 32'(outs), 32'(O_MEM));
      for (int i = 1; i <= 15; i++) begin
         cyc(); mid();
         check_val("to_wait", 32'(outs), 32'(O_MEM));
      end
      cyc(); mid();
      check_val("to_err", 32'(outs), 32'(O_ERR));
      check_val("to_cnt", 32'(stall_cnt), 32'd23);
      check_val("sat_cnt4", 32'(d4_stall_cnt), 32'd15);
      cyc(); dmem_req = 1'b0; dmem_ready = 1'b1; mid();
      check_val("err_sticky", 32'(outs), 32'(O_ERR));
      for (int i = 0; i < 4; i++) cyc();
      mid();
      check_val("err_cnt", 32'(stall_cnt), 32'd28);
      check_val("sat_cnt4_hold", 32'(d4_stall_cnt), 32'd15);
      cyc(); dmem_ready = 1'b0; rst = 1'b1; mid();
      check_val("rst_in_err", 32'(outs), 32'(O_RST));
      cyc(); mid();
      check_val("rst_err_cnt", 32'(stall_cnt), 32'd0);
      cyc(); rst = 1'b0; mid();
      check_val("run_after_err", 32'(outs), 32'(O_RUN));

      // Reset in the middle of a memory wait
      cyc(); dmem_req = 1'b1; mid();
      check_val("mw2_enter", 32'(outs), 32'(O_MEM));
      cyc(); mid();
      check_val("mw2_hold", 32'(outs), 32'(O_MEM));
      cyc(); rst = 1'b1; mid();
      check_val("rst_in_mw", 32'(outs), 32'(O_RST));
      cyc(); rst = 1'b0; dmem_req = 1'b0; mid();
      check_val("run_after_mw_rst", 32'(outs), 32'(O_RUN));
      check_val("mw_rst_cnt", 32'(stall_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
